// File: rtl/pc_fetch_unit.sv
//------------------------------------------------------------------------------
// Module      : pc_fetch_unit
// Description : Program counter and instruction-fetch sequencer. Fetches over a
//               req/ready bus and presents each instruction for one EXEC cycle.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        BranchCtr,
    input  logic        Jump,
    input  logic        JumpReg,
    input  logic [15:0] Imm16,
    input  logic [25:0] Target26,
    input  logic [31:0] RegData,
    input  logic        Halt,
    input  logic        IMemReady,
    input  logic [31:0] IMemData,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic [31:0] Instr,
    output logic        InstrValid,
    output logic        Halted,
    output logic        AddrErr,
    output logic        BusErr
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_HALT  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    // The edge that ends the MAX_WAIT-th FETCH cycle is the timeout edge.
    localparam logic [7:0] c_WAIT_LAST = 8'(MAX_WAIT - 1);

    logic [2:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [7:0]  r_waitCnt;
    logic        r_halted;
    logic        r_addrErr;
    logic        r_busErr;

    logic [31:0] w_pcPlus4;
    logic [31:0] w_brOffset;
    logic [31:0] w_target;
    logic        w_misaligned;

    assign w_pcPlus4  = r_pc + 32'd4;
    assign w_brOffset = {{14{Imm16[15]}}, Imm16, 2'b00};

    // Halt is resolved in the state logic; here only the redirect priority.
    always_comb begin
        w_target = w_pcPlus4;
        if (JumpReg) begin
            w_target = RegData;
        end else if (Jump) begin
            w_target = {w_pcPlus4[31:28], Target26, 2'b00};
        end else if (BranchCtr) begin
            w_target = w_pcPlus4 + w_brOffset;
        end
    end

    assign w_misaligned = |w_target[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_instr   <= 32'd0;
            r_waitCnt <= 8'd0;
            r_halted  <= 1'b0;
            r_addrErr <= 1'b0;
            r_busErr  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_FETCH;
                end
                S_FETCH: begin
                    if (IMemReady) begin
                        r_instr   <= IMemData;
                        r_waitCnt <= 8'd0;
                        r_state   <= S_EXEC;
                    end else if (r_waitCnt == c_WAIT_LAST) begin
                        r_waitCnt <= 8'd0;
                        r_busErr  <= 1'b1;
                        r_state   <= S_ERR;
                    end else begin
                        r_waitCnt <= r_waitCnt + 8'd1;
                    end
                end
                S_EXEC: begin
                    if (Halt) begin
                        r_halted <= 1'b1;
                        r_state  <= S_HALT;
                    end else if (w_misaligned) begin
                        // PC keeps the faulting instruction's address.
                        r_addrErr <= 1'b1;
                        r_state   <= S_ERR;
                    end else begin
                        r_pc    <= w_target;
                        r_state <= S_FETCH;
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                S_ERR: begin
                    r_state <= S_ERR;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign IMemReq    = (r_state == S_FETCH);
    assign InstrValid = (r_state == S_EXEC);
    assign IMemAddr   = r_pc;
    assign PC         = r_pc;
    assign PCPlus4    = w_pcPlus4;
    assign Instr      = r_instr;
    assign Halted     = r_halted;
    assign AddrErr    = r_addrErr;
    assign BusErr     = r_busErr;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
//------------------------------------------------------------------------------
// Module      : tb_pc_fetch_unit
// Description : Self-checking bench for pc_fetch_unit with a next-PC model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pc_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam int          MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        BranchCtr, Jump, JumpReg, Halt, IMemReady;
    logic [15:0] Imm16;
    logic [25:0] Target26;
    logic [31:0] RegData, IMemData;
    logic        IMemReq, InstrValid, Halted, AddrErr, BusErr;
    logic [31:0] IMemAddr, PC, PCPlus4, Instr;

    int nChecks = 0;
    int nErrors = 0;

    logic [31:0] mPc;
    logic [31:0] mInstr;
    bit          mTerm;

    always #5 clk = ~clk;

    pc_fetch_unit #(.RESET_PC(RESET_PC), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst), .BranchCtr(BranchCtr), .Jump(Jump), .JumpReg(JumpReg),
        .Imm16(Imm16), .Target26(Target26), .RegData(RegData), .Halt(Halt),
        .IMemReady(IMemReady), .IMemData(IMemData), .IMemReq(IMemReq),
        .IMemAddr(IMemAddr), .PC(PC), .PCPlus4(PCPlus4), .Instr(Instr),
        .InstrValid(InstrValid), .Halted(Halted), .AddrErr(AddrErr), .BusErr(BusErr)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Garbage on control inputs; only EXEC may look at them.
    task automatic randCtrl;
        BranchCtr = 1'($urandom);
        Jump      = 1'($urandom);
        JumpReg   = 1'($urandom);
        Halt      = 1'($urandom);
        Imm16     = 16'($urandom);
        Target26  = 26'($urandom);
        RegData   = $urandom;
        IMemData  = $urandom;
    endtask

    // Architectural next-PC rule, in plain arithmetic.
    function automatic logic [31:0] refTarget(input logic [31:0] pc, input logic jr, input logic j,
                                              input logic br, input logic [15:0] imm,
                                              input logic [25:0] t26, input logic [31:0] rd);
        logic [31:0] p4;
        p4 = pc + 32'd4;
        if (jr) return rd;
        if (j)  return (p4 & 32'hF000_0000) + 32'(t26) * 32'd4;
        if (br) return p4 + 32'(int'($signed(imm)) * 4);
        return p4;
    endfunction

    task automatic doReset;
        randCtrl();
        rst       = 1'b1;
        IMemReady = 1'($urandom);
        #1;
        checkVal("rstReq",   {31'd0, IMemReq}, 32'd0);
        checkVal("rstValid", {31'd0, InstrValid}, 32'd0);
        checkVal("rstPc",    PC, RESET_PC);
        checkVal("rstInstr", Instr, 32'd0);
        checkVal("rstFlags", {29'd0, Halted, AddrErr, BusErr}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        checkVal("idleReq", {31'd0, IMemReq}, 32'd0);
        tick();
        IMemReady = 1'b0;
        mPc    = RESET_PC;
        mInstr = 32'd0;
        mTerm  = 1'b0;
    endtask

    // Expects the DUT in FETCH; serves one instruction and executes it.
    task automatic runInstr(input int waits, input logic [31:0] data, input logic halt,
                            input logic jr, input logic j, input logic br,
                            input logic [15:0] imm, input logic [25:0] t26, input logic [31:0] rd);
        logic [31:0] tgt;
        int          stall;
        checkVal("fetchReq",   {31'd0, IMemReq}, 32'd1);
        checkVal("fetchAddr",  IMemAddr, mPc);
        checkVal("fetchValid", {31'd0, InstrValid}, 32'd0);
        stall = (waits < MAX_WAIT) ? waits : MAX_WAIT - 1;
        for (int i = 0; i < stall; i++) begin
            randCtrl();
            IMemReady = 1'b0;
            tick();
        end
        if (stall > 0) checkVal("waitState", {30'd0, IMemReq, BusErr}, 32'd2);
        if (waits >= MAX_WAIT) begin
            IMemReady = 1'b0;
            tick();
            checkVal("timeoutBus", {30'd0, BusErr, IMemReq}, 32'd2);
            checkVal("timeoutPc",  PC, mPc);
            checkVal("timeoutIns", Instr, mInstr);
            mTerm = 1'b1;
            return;
        end
        randCtrl();
        IMemReady = 1'b1;
        IMemData  = data;
        tick();
        IMemReady = 1'($urandom);
        mInstr    = data;
        checkVal("execValid", {30'd0, InstrValid, IMemReq}, 32'd2);
        checkVal("execInstr", Instr, data);
        checkVal("execPc",    PC, mPc);
        checkVal("execPc4",   PCPlus4, mPc + 32'd4);
        Halt = halt; JumpReg = jr; Jump = j; BranchCtr = br;
        Imm16 = imm; Target26 = t26; RegData = rd;
        tgt = refTarget(mPc, jr, j, br, imm, t26, rd);
        tick();
        randCtrl();
        IMemReady = 1'b0;
        if (halt) begin
            checkVal("haltFlag", {29'd0, Halted, InstrValid, IMemReq}, 32'd4);
            checkVal("haltPc",   PC, mPc);
            mTerm = 1'b1;
        end else if (tgt[1:0] != 2'b00) begin
            checkVal("alignFlag", {29'd0, AddrErr, InstrValid, IMemReq}, 32'd4);
            checkVal("alignPc",   PC, mPc);
            mTerm = 1'b1;
        end else begin
            mPc = tgt;
            checkVal("nextFlags", {29'd0, Halted, AddrErr, BusErr}, 32'd0);
        end
    endtask

    // Terminal states must stay silent and frozen.
    task automatic checkIdle(input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            randCtrl();
            IMemReady = 1'($urandom);
            tick();
            if (IMemReq || InstrValid) bad++;
            if (PC !== mPc || Instr !== mInstr) bad++;
        end
        checkVal("termIdle", 32'(bad), 32'd0);
    endtask

    task automatic plain(input logic [31:0] data);
        runInstr(0, data, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 26'd0, 32'd0);
    endtask

    initial begin
        logic        rHalt, rJr, rJ, rBr;
        logic [31:0] rRd;
        int          rWaits;

        rst = 1'b1;
        IMemReady = 1'b0;
        randCtrl();

        // Zero-wait fetch of two instructions
        doReset();
        checkVal("tpAddr0", IMemAddr, 32'h3000);
        plain(32'h2008_0001);
        checkVal("tpAddr1", IMemAddr, 32'h3004);
        plain(32'h2009_0002);
        plain($urandom);
        plain($urandom);
        checkVal("tpAddr10", IMemAddr, 32'h3010);
        runInstr(0, $urandom, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFC, 26'd0, 32'd0);
        checkVal("tpBrTaken", IMemAddr, 32'h3004);
        plain($urandom);
        plain($urandom);
        plain($urandom);
        runInstr(0, $urandom, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFC, 26'd0, 32'd0);
        checkVal("tpBrNot", IMemAddr, 32'h3014);

        // Jump beats branch
        doReset();
        runInstr(0, $urandom, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0010, 26'h0000C40, 32'd0);
        checkVal("tpJump", IMemAddr, 32'h3100);

        // Misaligned register jump
        doReset();
        runInstr(0, $urandom, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 26'd0, 32'h3002);
        checkVal("tpAlign", {PC[30:0], AddrErr}, {31'h3000, 1'b1});
        checkIdle(5);
        doReset();

        // Halt beats register jump
        runInstr(0, $urandom, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 26'd0, 32'h4000);
        checkVal("tpHalt", {PC[30:0], Halted}, {31'h3000, 1'b1});
        checkIdle(20);

        // Wait states, timeout, and ready on the timeout edge
        doReset();
        runInstr(3, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 26'd0, 32'd0);
        checkVal("tpWait3", {31'd0, BusErr}, 32'd0);
        runInstr(MAX_WAIT, $urandom, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 26'd0, 32'd0);
        checkIdle(4);
        doReset();
        runInstr(MAX_WAIT - 1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 26'd0, 32'd0);
        checkVal("tpEdgeReady", {30'd0, BusErr, IMemReq}, 32'd1);

        // Reset in the middle of a fetch drops the response
        IMemReady = 1'b0;
        tick();
        tick();
        doReset();
        plain(32'hCAFE_0001);

        // Randomized instruction stream
        for (int n = 0; n < 300; n++) begin
            if (mTerm) begin
                checkIdle(3);
                doReset();
            end
            rHalt  = ($urandom_range(0, 29) == 0);
            rJr    = ($urandom_range(0, 5) == 0);
            rJ     = ($urandom_range(0, 4) == 0);
            rBr    = 1'($urandom);
            rRd    = $urandom;
            if ($urandom_range(0, 9) != 0) rRd[1:0] = 2'b00;
            rWaits = ($urandom_range(0, 19) == 0) ? int'($urandom_range(13, 16))
                                                  : int'($urandom_range(0, 3));
            runInstr(rWaits, $urandom, rHalt, rJr, rJ, rBr, 16'($urandom), 26'($urandom), rRd);
        end

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule

`default_nettype wire
